// File: rtl/keyb_matrix_scanner.sv
// Keyboard matrix scanner: drives one open-drain row at a time and waits for the
// columns to settle. It then samples the synchronised columns, debounces every key
// and queues press/release events in a small first-word-fallthrough FIFO.
module keyb_matrix_scanner #(
    parameter int ROWS           = 8,
    parameter int COLS           = 3,
    parameter int SETTLE_CYC     = 250,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         scan_en_i,
    output logic [ROWS-1:0]              row_oe_o,
    input  logic [COLS-1:0]              col_i,
    output logic [ROWS*COLS-1:0]         key_mask_o,
    output logic                         event_valid_o,
    output logic [$clog2(ROWS*COLS)-1:0] event_key_o,
    output logic                         event_press_o,
    input  logic                         event_rd_i,
    output logic                         overflow_o
);

    localparam int NK = ROWS * COLS;
    localparam int KW = $clog2(NK);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int SW = $clog2(SETTLE_CYC);
    localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [2:0] {IDLE, DRIVE, SAMPLE, COMMIT, GAP} state_t;

    state_t            state_reg, state_next;
    logic [RW-1:0]     row_reg, row_next;
    logic [SW-1:0]     cnt_reg, cnt_next;
    logic [CW-1:0]     col_reg, col_next;
    logic [COLS-1:0]   smp_reg, smp_next;
    logic [ROWS-1:0]   row_oe_reg, row_oe_next;
    logic [COLS-1:0]   col_s1_reg, col_s2_reg;
    logic [NK-1:0]     stable_reg;
    logic [DW-1:0]     dcnt_reg [NK];

    logic [KW-1:0]     fifo_key_mem   [FIFO_DEPTH];
    logic              fifo_press_mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]       count_reg;
    logic              overflow_reg;

    logic              drive_next;
    logic [KW-1:0]     cur_key;
    logic              smp_bit, cur_stable, deb_last, commit, push, pop, full, wr_en;

    // Two-flop synchroniser on the asynchronous column inputs; idle level is released (1).
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            col_s1_reg <= '1;
            col_s2_reg <= '1;
        end else begin
            col_s1_reg <= col_i;
            col_s2_reg <= col_s1_reg;
        end
    end

    // Scan sequencer state register; reset aborts any row in progress.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_reg  <= IDLE;
            row_reg    <= '0;
            cnt_reg    <= '0;
            col_reg    <= '0;
            smp_reg    <= '0;
            row_oe_reg <= '0;
        end else begin
            state_reg  <= state_next;
            row_reg    <= row_next;
            cnt_reg    <= cnt_next;
            col_reg    <= col_next;
            smp_reg    <= smp_next;
            row_oe_reg <= row_oe_next;
        end
    end

    // Next-state logic: drive, settle, sample, commit one column per cycle, then advance row.
    always_comb begin
        state_next = state_reg;
        row_next   = row_reg;
        cnt_next   = cnt_reg;
        col_next   = col_reg;
        smp_next   = smp_reg;
        case (state_reg)
            IDLE: begin
                if (scan_en_i) begin
                    state_next = DRIVE;
                    cnt_next   = '0;
                end
            end
            DRIVE: begin
                if (cnt_reg == SW'(SETTLE_CYC - 1)) state_next = SAMPLE;
                else                                cnt_next   = cnt_reg + 1'b1;
            end
            SAMPLE: begin
                smp_next   = ~col_s2_reg;
                col_next   = '0;
                state_next = COMMIT;
            end
            COMMIT: begin
                if (col_reg == CW'(COLS - 1)) state_next = GAP;
                else                          col_next   = col_reg + 1'b1;
            end
            GAP: begin
                row_next = (row_reg == RW'(ROWS - 1)) ? '0 : row_reg + 1'b1;
                if (scan_en_i) begin
                    state_next = DRIVE;
                    cnt_next   = '0;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Row enables are registered so the open-drain buffers never see decode glitches.
    assign drive_next = (state_next == DRIVE) || (state_next == SAMPLE);
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row_oe
        assign row_oe_next[gi] = drive_next && (row_next == RW'(gi));
    end

    assign cur_key    = KW'(row_reg) * KW'(COLS) + KW'(col_reg);
    assign smp_bit    = smp_reg[col_reg];
    assign cur_stable = stable_reg[cur_key];
    assign deb_last   = (dcnt_reg[cur_key] == DW'(DEBOUNCE_SCANS - 1));
    assign commit     = (state_reg == COMMIT);
    assign push       = commit && (smp_bit != cur_stable) && deb_last;

    // Per-key debounce: count consecutive disagreeing scans, flip stable state on the last one.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            stable_reg <= '0;
            for (int k = 0; k < NK; k++) dcnt_reg[k] <= '0;
        end else if (commit) begin
            if (smp_bit == cur_stable) begin
                dcnt_reg[cur_key] <= '0;
            end else if (deb_last) begin
                stable_reg[cur_key] <= smp_bit;
                dcnt_reg[cur_key]   <= '0;
            end else begin
                dcnt_reg[cur_key] <= dcnt_reg[cur_key] + 1'b1;
            end
        end
    end

    // A pop frees a slot in the same cycle, so a push into a full FIFO with a pop still lands.
    assign pop   = event_rd_i && (count_reg != '0);
    assign full  = (count_reg == (AW+1)'(FIFO_DEPTH));
    assign wr_en = push && (!full || pop);

    // Event storage; a shallow array read asynchronously so the head falls through.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            fifo_key_mem[wr_ptr_reg]   <= cur_key;
            fifo_press_mem[wr_ptr_reg] <= smp_bit;
        end
    end

    // FIFO pointers, occupancy and the sticky drop flag.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)   rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (wr_en && !pop)      count_reg <= count_reg + 1'b1;
            else if (!wr_en && pop) count_reg <= count_reg - 1'b1;
            if (push && full && !pop) overflow_reg <= 1'b1;
        end
    end

    assign row_oe_o      = row_oe_reg;
    assign key_mask_o    = stable_reg;
    assign event_valid_o = (count_reg != '0);
    assign event_key_o   = event_valid_o ? fifo_key_mem[rd_ptr_reg] : '0;
    assign event_press_o = event_valid_o ? fifo_press_mem[rd_ptr_reg] : 1'b0;
    assign overflow_o    = overflow_reg;

endmodule

// File: tb/tb_keyb_matrix_scanner.sv
// Directed bench for keyb_matrix_scanner with a behavioural key matrix and an event scoreboard.
module tb_keyb_matrix_scanner;

    localparam int ROWS = 8;
    localparam int COLS = 3;

    logic        clk = 1'b0;
    logic        rst_n, scan_en, event_rd;
    logic [7:0]  row_oe;
    logic [2:0]  col;
    logic [23:0] key_mask;
    logic        event_valid, event_press, overflow;
    logic [4:0]  event_key;

    logic [23:0] pressed;
    logic [23:0] exp_mask;
    logic [5:0]  exp_q [$];
    logic [5:0]  head;
    logic [7:0]  e8;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    keyb_matrix_scanner #(
        .ROWS(8), .COLS(3), .SETTLE_CYC(4), .DEBOUNCE_SCANS(2), .FIFO_DEPTH(4)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .scan_en_i(scan_en), .row_oe_o(row_oe),
        .col_i(col), .key_mask_o(key_mask), .event_valid_o(event_valid),
        .event_key_o(event_key), .event_press_o(event_press),
        .event_rd_i(event_rd), .overflow_o(overflow)
    );

    // Open-drain matrix: a closed key pulls its column low while its row is driven.
    always_comb begin
        col = 3'b111;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (row_oe[r] && pressed[r*COLS+c]) col[c] = 1'b0;
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Stop at the first cycle row 0 is driven in a scan (scan offset i=0).
    task automatic align();
        logic prev;
        prev = (row_oe == 8'h01);
        for (int n = 0; n < 200; n++) begin
            step();
            if (row_oe == 8'h01 && !prev) return;
            prev = (row_oe == 8'h01);
        end
        total++;
        bad++;
        $error("FAIL align timeout observed=0x%0h expected=0x01", row_oe);
    endtask

    // Pop n events, comparing each against the scoreboard head.
    task automatic drain(input int n, input string tag);
        logic [5:0] e;
        int w;
        for (int j = 0; j < n; j++) begin
            w = 0;
            while (!event_valid && w < 200) begin
                step();
                w++;
            end
            if (!event_valid) begin
                total++;
                bad++;
                $error("FAIL %s timeout observed=0 expected=1", tag);
                return;
            end
            e = exp_q.pop_front();
            chk({tag, " key"}, 32'(event_key), 32'(e[4:0]));
            chk({tag, " press"}, 32'(event_press), 32'(e[5]));
            event_rd = 1'b1;
            step();
            event_rd = 1'b0;
        end
        chk({tag, " empty"}, 32'(event_valid), 32'h0);
    endtask

    // Change one key at scan start; the flip lands in the second scan's COMMIT of that key.
    task automatic key_exact(input int k, input logic v, input string tag);
        int t;
        t = 78 + 9 * (k / 3) + (k % 3);
        align();
        pressed[k]  = v;
        exp_mask[k] = v;
        exp_q.push_back({v, 5'(k)});
        repeat (t - 1) step();
        chk({tag, " early"}, 32'(event_valid), 32'h0);
        step();
        chk({tag, " valid"}, 32'(event_valid), 32'h1);
        chk({tag, " mask"}, 32'(key_mask), 32'(exp_mask));
        drain(1, tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; scan_en = 1'b0; event_rd = 1'b0;
        pressed = '0; exp_mask = '0;
        repeat (3) step();
        chk("rst row_oe", 32'(row_oe), 32'h0);
        chk("rst mask", 32'(key_mask), 32'h0);
        chk("rst valid", 32'(event_valid), 32'h0);
        chk("rst key", 32'(event_key), 32'h0);
        chk("rst press", 32'(event_press), 32'h0);
        chk("rst overflow", 32'(overflow), 32'h0);

        // T1: scan order and row timing over more than one full scan
        rst_n = 1'b1; scan_en = 1'b1;
        for (int i = 0; i < 81; i++) begin
            step();
            e8 = ((i % 9) < 5) ? 8'(1 << ((i / 9) % 8)) : 8'h00;
            chk($sformatf("t1 row_oe[%0d]", i), 32'(row_oe), 32'(e8));
        end
        chk("t1 no events", 32'(event_valid), 32'h0);

        // T2: press and release key 7 (row 2, col 1)
        key_exact(7, 1'b1, "t2 press");
        key_exact(7, 1'b0, "t2 release");

        // T3: single-scan bounce produces nothing and leaves the counter cleared
        align();
        pressed[7] = 1'b1;
        repeat (30) step();
        pressed[7] = 1'b0;
        repeat (120) step();
        chk("t3 no event", 32'(event_valid), 32'h0);
        chk("t3 mask", 32'(key_mask), 32'(exp_mask));
        key_exact(7, 1'b1, "t3 repress");
        key_exact(7, 1'b0, "t3 rerelease");

        // T6a: scan_en drop during row 3 drive finishes the row then idles
        align();
        repeat (28) step();
        scan_en = 1'b0;
        chk("t6 stop drive", 32'(row_oe), 32'h08);
        repeat (3) step();
        chk("t6 stop sample", 32'(row_oe), 32'h08);
        step();
        chk("t6 stop commit", 32'(row_oe), 32'h00);
        repeat (4) step();
        chk("t6 stop idle", 32'(row_oe), 32'h00);
        repeat (20) step();
        chk("t6 stop idle late", 32'(row_oe), 32'h00);
        scan_en = 1'b1;

        // T4: five flips with no pops -> four queued, one dropped
        align();
        pressed[0] = 1'b1; pressed[4] = 1'b1; pressed[11] = 1'b1;
        pressed[15] = 1'b1; pressed[22] = 1'b1;
        exp_mask = pressed;
        exp_q.push_back({1'b1, 5'd0});
        exp_q.push_back({1'b1, 5'd4});
        exp_q.push_back({1'b1, 5'd11});
        exp_q.push_back({1'b1, 5'd15});
        repeat (146) step();
        chk("t4 overflow", 32'(overflow), 32'h1);
        chk("t4 mask", 32'(key_mask), 32'(exp_mask));
        drain(4, "t4");

        // T6b: reset mid-DRIVE with a queued event and sticky overflow set
        align();
        pressed[7] = 1'b1;
        exp_mask[7] = 1'b1;
        repeat (146) step();
        chk("t6 prep valid", 32'(event_valid), 32'h1);
        chk("t6 prep mask", 32'(key_mask), 32'(exp_mask));
        align();
        repeat (2) step();
        chk("t6 mid drive", 32'(row_oe), 32'h01);
        rst_n = 1'b0;
        step();
        chk("t6 rst row_oe", 32'(row_oe), 32'h0);
        chk("t6 rst mask", 32'(key_mask), 32'h0);
        chk("t6 rst valid", 32'(event_valid), 32'h0);
        chk("t6 rst key", 32'(event_key), 32'h0);
        chk("t6 rst press", 32'(event_press), 32'h0);
        chk("t6 rst overflow", 32'(overflow), 32'h0);
        exp_q.delete();
        exp_mask = '0;
        pressed = '0;
        rst_n = 1'b1;

        // T5: full FIFO, pop in the same cycle as a new push
        align();
        pressed[0] = 1'b1; pressed[4] = 1'b1; pressed[11] = 1'b1;
        pressed[15] = 1'b1; pressed[22] = 1'b1;
        exp_mask = pressed;
        exp_q.push_back({1'b1, 5'd0});
        exp_q.push_back({1'b1, 5'd4});
        exp_q.push_back({1'b1, 5'd11});
        exp_q.push_back({1'b1, 5'd15});
        exp_q.push_back({1'b1, 5'd22});
        repeat (141) step();
        chk("t5 full valid", 32'(event_valid), 32'h1);
        head = exp_q.pop_front();
        chk("t5 head key", 32'(event_key), 32'(head[4:0]));
        chk("t5 head press", 32'(event_press), 32'(head[5]));
        event_rd = 1'b1;
        step();
        event_rd = 1'b0;
        chk("t5 overflow", 32'(overflow), 32'h0);
        chk("t5 mask", 32'(key_mask), 32'(exp_mask));
        drain(4, "t5");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
